// File: rtl/processor.sv
// asm18 single-cycle 18-bit RISC core: fetch from async code memory, execute, retire.
// Ports: clock, reset (sync, active-high), code_addr (PC out), code_word (instruction in).
module processor_regs #(
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [2:0]           wa,
  input  logic [WORD_SIZE-1:0] wd,
  input  logic [2:0]           ra_a,
  output logic [WORD_SIZE-1:0] rd_a,
  input  logic [2:0]           ra_b,
  output logic [WORD_SIZE-1:0] rd_b
);

  logic [WORD_SIZE-1:0] regs [0:7];

  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

endmodule

module processor #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [ADDR_SIZE-1:0] code_addr,
  input  logic [WORD_SIZE-1:0] code_word
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOVI = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_ADDI = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JNZ  = 4'hA,
    OP_SHL  = 4'hB,
    OP_SHR  = 4'hC,
    OP_HALT = 4'hD
  } op_t;

  logic [ADDR_SIZE-1:0] pc;
  logic [ADDR_SIZE-1:0] pc_next;
  logic                 halted;
  logic                 halt_next;

  logic [3:0] op;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;

  logic [WORD_SIZE-1:0] imm11_w;
  logic [WORD_SIZE-1:0] imm8_w;
  logic [ADDR_SIZE-1:0] imm11_a;
  logic [ADDR_SIZE-1:0] imm14_a;

  logic                 we;
  logic [WORD_SIZE-1:0] wd;
  logic [2:0]           ra_a;
  logic [WORD_SIZE-1:0] va;
  logic [WORD_SIZE-1:0] vb;

  assign op  = code_word[17:14];
  assign rd  = code_word[13:11];
  assign rs1 = code_word[10:8];
  assign rs2 = code_word[7:5];

  assign imm11_w = {{(WORD_SIZE-11){code_word[10]}}, code_word[10:0]};
  assign imm8_w  = {{(WORD_SIZE-8){code_word[7]}}, code_word[7:0]};
  assign imm11_a = {{(ADDR_SIZE-11){code_word[10]}}, code_word[10:0]};
  assign imm14_a = {{(ADDR_SIZE-14){1'b0}}, code_word[13:0]};

  // Branches test rd, so port A is steered to rd for JZ/JNZ.
  assign ra_a = (op == OP_JZ || op == OP_JNZ) ? rd : rs1;

  assign code_addr = pc;

  processor_regs #(
    .WORD_SIZE(WORD_SIZE)
  ) registers (
    .clock(clock),
    .reset(reset),
    .we   (we & ~halted),
    .wa   (rd),
    .wd   (wd),
    .ra_a (ra_a),
    .rd_a (va),
    .ra_b (rs2),
    .rd_b (vb)
  );

  always_comb begin
    we        = 1'b0;
    wd        = '0;
    pc_next   = pc + 1'b1;
    halt_next = halted;
    unique case (op)
      OP_MOVI: begin
        we = 1'b1;
        wd = imm11_w;
      end
      OP_ADD: begin
        we = 1'b1;
        wd = va + vb;
      end
      OP_SUB: begin
        we = 1'b1;
        wd = va - vb;
      end
      OP_AND: begin
        we = 1'b1;
        wd = va & vb;
      end
      OP_OR: begin
        we = 1'b1;
        wd = va | vb;
      end
      OP_XOR: begin
        we = 1'b1;
        wd = va ^ vb;
      end
      OP_ADDI: begin
        we = 1'b1;
        wd = va + imm8_w;
      end
      OP_JMP: begin
        pc_next = imm14_a;
      end
      OP_JZ: begin
        if (va == '0) pc_next = pc + imm11_a;
      end
      OP_JNZ: begin
        if (va != '0) pc_next = pc + imm11_a;
      end
      OP_SHL: begin
        we = 1'b1;
        wd = {va[WORD_SIZE-2:0], 1'b0};
      end
      OP_SHR: begin
        we = 1'b1;
        wd = {1'b0, va[WORD_SIZE-1:1]};
      end
      OP_HALT: begin
        pc_next   = pc;
        halt_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      pc     <= pc_next;
      halted <= halt_next;
    end
  end

endmodule

// File: tb/tb_processor.sv
// Scoreboard bench for processor: directed programs, expected state queued,
// negedge monitor compares code_addr and register contents.
module tb_processor;

  logic        clock;
  logic        reset;
  logic [17:0] code_addr;
  logic [17:0] code_word;

  logic [17:0] mem [0:63];

  typedef struct {
    string       name;
    int          sel;
    logic [17:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_bad;

  processor dut (
    .clock    (clock),
    .reset    (reset),
    .code_addr(code_addr),
    .code_word(code_word)
  );

  assign code_word = (code_addr < 18'd64) ? mem[code_addr[5:0]] : 18'h0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    exp_t        e;
    logic [17:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel < 0) act = code_addr;
      else act = dut.registers.regs[e.sel];
      n_vec++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %05h expected %05h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_pc(input string nm, input logic [17:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = -1;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic expect_reg(input string nm, input int r, input logic [17:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = r;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 18'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    clear_mem();

    // Reset with NOP memory
    do_reset();
    expect_pc("rst_pc", 18'h0);
    for (int i = 0; i < 8; i++) expect_reg($sformatf("rst_r%0d", i), i, 18'h0);
    drain();
    step(1);
    expect_pc("nop_pc", 18'h1);
    drain();

    // Arithmetic
    clear_mem();
    mem[0] = 18'h04005;
    mem[1] = 18'h04807;
    mem[2] = 18'h08020;
    do_reset();
    step(3);
    expect_reg("add_r0", 0, 18'h0000C);
    expect_reg("add_r1", 1, 18'h00007);
    expect_pc("add_pc", 18'h3);
    drain();

    // Wrap on SUB then ADDI
    clear_mem();
    mem[0] = 18'h04000;
    mem[1] = 18'h04801;
    mem[2] = 18'h0D020;
    mem[3] = 18'h1DA01;
    do_reset();
    step(3);
    expect_reg("sub_wrap", 2, 18'h3FFFF);
    drain();
    step(1);
    expect_reg("addi_wrap", 3, 18'h00000);
    drain();

    // Negative immediate
    clear_mem();
    mem[0] = 18'h047FF;
    do_reset();
    step(1);
    expect_reg("movi_neg", 0, 18'h3FFFF);
    drain();

    // Logic, shifts, self-source reads, reserved opcodes
    clear_mem();
    mem[0]  = 18'h06155;
    mem[1]  = 18'h06FFE;
    mem[2]  = 18'h134A0;
    mem[3]  = 18'h17CA0;
    mem[4]  = 18'h184A0;
    mem[5]  = 18'h2CD00;
    mem[6]  = 18'h31500;
    mem[7]  = 18'h09DA0;
    mem[8]  = 18'h1E4FF;
    mem[9]  = 18'h3FFFF;
    mem[10] = 18'h38123;
    do_reset();
    step(9);
    expect_reg("movi_r5", 5, 18'h3FFFE);
    expect_reg("and_r6", 6, 18'h00154);
    expect_reg("or_r7", 7, 18'h3FFFF);
    expect_reg("xor_r0", 0, 18'h3FEAB);
    expect_reg("shl_r1", 1, 18'h3FFFC);
    expect_reg("shr_r2", 2, 18'h1FFFF);
    expect_reg("add_self", 3, 18'h3FFFC);
    expect_reg("addi_self", 4, 18'h00154);
    expect_pc("logic_pc", 18'h9);
    drain();
    step(2);
    expect_pc("rsvd_pc", 18'hB);
    expect_reg("rsvd_r4", 4, 18'h00154);
    expect_reg("rsvd_r7", 7, 18'h3FFFF);
    drain();

    // Jump, taken JZ backwards, untaken JNZ, HALT
    clear_mem();
    mem[0]  = 18'h20010;
    mem[16] = 18'h247FC;
    mem[12] = 18'h28005;
    mem[13] = 18'h34000;
    do_reset();
    step(1);
    expect_pc("jmp_pc", 18'h10);
    drain();
    step(1);
    expect_pc("jz_taken", 18'h0C);
    drain();
    step(1);
    expect_pc("jnz_untaken", 18'h0D);
    drain();
    step(3);
    expect_pc("halt_hold", 18'h0D);
    drain();

    // Branch target wraps below zero, then PC+1 wraps to 0
    clear_mem();
    mem[0] = 18'h247FF;
    do_reset();
    step(1);
    expect_pc("br_wrap", 18'h3FFFF);
    drain();
    step(1);
    expect_pc("pc_wrap", 18'h0);
    drain();

    // Countdown loop then reset while halted
    clear_mem();
    mem[0] = 18'h04003;
    mem[1] = 18'h1C0FF;
    mem[2] = 18'h287FF;
    mem[3] = 18'h34000;
    do_reset();
    step(12);
    expect_reg("loop_r0", 0, 18'h0);
    expect_pc("loop_halt_pc", 18'h3);
    drain();
    do_reset();
    expect_pc("rerst_pc", 18'h0);
    expect_reg("rerst_r0", 0, 18'h0);
    drain();
    step(1);
    expect_pc("resume_pc", 18'h1);
    expect_reg("resume_r0", 0, 18'h3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
